// File: rtl/alu_issue_if.sv
// alu_issue_if: request/response handshake bundle between a requester and alu_issue_ctrl
//   req_valid/req_ready   request handshake
//   req_op, req_a, req_b  operation code and operands
//   resp_valid/resp_ready response handshake
//   resp_result, resp_zero, resp_err  captured ALU result, zero flag, illegal-request flag
interface alu_issue_if #(parameter int WIDTH = 8);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic             resp_zero;
    logic             resp_err;
    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero, resp_err
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero, resp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one request at a time through a combinational ALU and returns the result
//   clk, reset          rising-edge clock, synchronous active-high reset
//   bus (slave)         request/response handshake channels
//   alu_a, alu_b        registered operands driven to the ALU
//   alu_control         registered op code driven to the ALU
//   alu_result, alu_zero combinational ALU outputs, captured in EXEC
//   busy                high outside IDLE
//   ops_count           retired responses (including errors), wraps silently
module alu_issue_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_if.slave       bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy,
    output logic [CNT_W-1:0] ops_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state, state_n;
    logic             accept, illegal, retire;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, err_q;
    // Undefined op codes and divide-by-zero never reach the ALU
    assign illegal = (bus.req_op > 4'd9) || (bus.req_op == 4'd6 && bus.req_b == '0);
    assign accept  = state == IDLE && bus.req_valid;
    assign retire  = state == RESP && bus.resp_ready;
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_n;
    end
    always_comb begin
        state_n = state;
        if (accept)
            state_n = illegal ? RESP : EXEC;
        else if (state == EXEC)
            state_n = RESP;
        else if (retire)
            state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            ops_count   <= '0;
        end else begin
            if (accept && !illegal) begin
                alu_a       <= bus.req_a;
                alu_b       <= bus.req_b;
                alu_control <= bus.req_op;
            end
            if (accept && illegal) begin
                result_q <= '0;
                zero_q   <= 1'b0;
                err_q    <= 1'b1;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
                err_q    <= 1'b0;
            end
            if (retire)
                ops_count <= ops_count + 1'b1;
        end
    end
    assign bus.req_ready   = state == IDLE;
    assign bus.resp_valid  = state == RESP;
    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;
    assign bus.resp_err    = err_q;
    assign busy            = state != IDLE;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl driving a small ALU model
//   instantiates alu_issue_if and the DUT with CNT_W=4 so counter wrap is reachable
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_control;
    logic       alu_zero, busy;
    logic [3:0] ops_count;
    int         vecs = 0;
    int         errs = 0;

    alu_issue_if #(.WIDTH(8)) bus ();

    alu_issue_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .ops_count(ops_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = 8'h00;
        case (alu_control)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a | alu_b;
            4'd4: alu_result = ~(alu_a | alu_b);
            4'd5: alu_result = alu_a ^ alu_b;
            4'd6: alu_result = (alu_b == 8'h00) ? 8'h00 : alu_a / alu_b;
            4'd7: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 8'h01 : 8'h00;
            4'd8: alu_result = alu_a << alu_b;
            4'd9: alu_result = alu_a >> alu_b;
            default: alu_result = 8'h00;
        endcase
        alu_zero = alu_result == 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vecs++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_zero, busy} !== 5'b10000) begin
            errs++;
            $display("FAIL reset_flags got %b want 10000", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_zero, busy});
        end
        vecs++;
        if ({bus.resp_result, alu_a, alu_b, alu_control, ops_count} !== 32'h0) begin
            errs++;
            $display("FAIL reset_values got %h want 0", {bus.resp_result, alu_a, alu_b, alu_control, ops_count});
        end
    endtask

    task automatic test_add();
        bus.resp_ready = 1'b1;
        issue(4'd0, 8'h0F, 8'h01);
        vecs++;
        if ({busy, bus.req_ready, bus.resp_valid, alu_control, alu_a, alu_b} !== {3'b100, 4'd0, 8'h0F, 8'h01}) begin
            errs++;
            $display("FAIL add_exec got %h want %h", {busy, bus.req_ready, bus.resp_valid, alu_control, alu_a, alu_b}, {3'b100, 4'd0, 8'h0F, 8'h01});
        end
        tick();
        vecs++;
        if ({bus.resp_valid, bus.resp_result, bus.resp_zero, bus.resp_err} !== {1'b1, 8'h10, 2'b00}) begin
            errs++;
            $display("FAIL add_resp got %h want %h", {bus.resp_valid, bus.resp_result, bus.resp_zero, bus.resp_err}, {1'b1, 8'h10, 2'b00});
        end
        tick();
        vecs++;
        if ({bus.resp_valid, bus.req_ready, ops_count} !== {2'b01, 4'd1}) begin
            errs++;
            $display("FAIL add_retire got %b want %b", {bus.resp_valid, bus.req_ready, ops_count}, {2'b01, 4'd1});
        end
    endtask

    task automatic test_illegal();
        logic [3:0] ops [2];
        logic [7:0] bs [2];
        ops = '{4'd6, 4'd15};
        bs  = '{8'h00, 8'h55};
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 8'hAA, bs[i]);
            vecs++;
            if ({bus.resp_valid, bus.resp_err, bus.resp_result, bus.resp_zero, busy} !== {2'b11, 8'h00, 2'b01}) begin
                errs++;
                $display("FAIL illegal_resp%0d got %h want %h", i, {bus.resp_valid, bus.resp_err, bus.resp_result, bus.resp_zero, busy}, {2'b11, 8'h00, 2'b01});
            end
            vecs++;
            if ({alu_control, alu_a, alu_b} !== {4'd0, 8'h0F, 8'h01}) begin
                errs++;
                $display("FAIL illegal_alu%0d got %h want %h", i, {alu_control, alu_a, alu_b}, {4'd0, 8'h0F, 8'h01});
            end
            tick();
            vecs++;
            if ({bus.resp_valid, ops_count} !== {1'b0, 4'(i + 2)}) begin
                errs++;
                $display("FAIL illegal_retire%0d got %h want %h", i, {bus.resp_valid, ops_count}, {1'b0, 4'(i + 2)});
            end
        end
    endtask

    task automatic test_backpressure();
        bus.resp_ready = 1'b0;
        issue(4'd1, 8'h33, 8'h33);
        tick();
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if ({bus.resp_valid, bus.req_ready, bus.resp_result, bus.resp_zero, bus.resp_err} !== {2'b10, 8'h00, 2'b10}) begin
                errs++;
                $display("FAIL bp_hold%0d got %h want %h", i, {bus.resp_valid, bus.req_ready, bus.resp_result, bus.resp_zero, bus.resp_err}, {2'b10, 8'h00, 2'b10});
            end
            tick();
        end
        bus.resp_ready = 1'b1;
        vecs++;
        if ({bus.resp_valid, ops_count} !== {1'b1, 4'd3}) begin
            errs++;
            $display("FAIL bp_before got %h want %h", {bus.resp_valid, ops_count}, {1'b1, 4'd3});
        end
        tick();
        vecs++;
        if ({bus.resp_valid, bus.req_ready, ops_count} !== {2'b01, 4'd4}) begin
            errs++;
            $display("FAIL bp_retire got %h want %h", {bus.resp_valid, bus.req_ready, ops_count}, {2'b01, 4'd4});
        end
    endtask

    task automatic test_reset_exec();
        bus.resp_ready = 1'b1;
        issue(4'd0, 8'h01, 8'h02);
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL rexec_busy got %b want 1", busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vecs++;
        if ({bus.req_ready, busy, ops_count, bus.resp_valid, bus.resp_result, bus.resp_zero, bus.resp_err} !== {2'b10, 4'd0, 1'b0, 8'h00, 2'b00}) begin
            errs++;
            $display("FAIL rexec_after got %h want %h", {bus.req_ready, busy, ops_count, bus.resp_valid, bus.resp_result, bus.resp_zero, bus.resp_err}, {2'b10, 4'd0, 1'b0, 8'h00, 2'b00});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if ({bus.resp_valid, ops_count} !== 5'b0) begin
                errs++;
                $display("FAIL rexec_quiet%0d got %h want 0", i, {bus.resp_valid, ops_count});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [5];
        logic [7:0] as [5];
        logic [7:0] bs [5];
        logic [7:0] exp [5];
        int acc = 0;
        int got = 0;
        int last = -1;
        ops = '{4'd8, 4'd9, 4'd5, 4'd7, 4'd6};
        as  = '{8'h01, 8'h80, 8'hA5, 8'h02, 8'h09};
        bs  = '{8'h03, 8'h07, 8'h0F, 8'h05, 8'h03};
        exp = '{8'h08, 8'h01, 8'hAA, 8'h01, 8'h03};
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_op = ops[0];
        bus.req_a  = as[0];
        bus.req_b  = bs[0];
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (bus.resp_valid) begin
                vecs++;
                if ({bus.resp_result, bus.resp_err} !== {exp[got], 1'b0}) begin
                    errs++;
                    $display("FAIL b2b_result%0d got %h want %h", got, {bus.resp_result, bus.resp_err}, {exp[got], 1'b0});
                end
                got++;
            end
            if (bus.req_ready && acc < 5) begin
                if (last >= 0) begin
                    vecs++;
                    if (c - last != 3) begin
                        errs++;
                        $display("FAIL b2b_spacing%0d got %0d want 3", acc, c - last);
                    end
                end
                last = c;
                acc++;
            end
            tick();
            if (acc < 5) begin
                bus.req_op = ops[acc];
                bus.req_a  = as[acc];
                bus.req_b  = bs[acc];
            end else
                bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        vecs++;
        if (got != 5 || acc != 5) begin
            errs++;
            $display("FAIL b2b_count got %0d/%0d want 5/5", got, acc);
        end
        vecs++;
        if (ops_count !== 4'd5) begin
            errs++;
            $display("FAIL b2b_ops got %0d want 5", ops_count);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(4'd0, 8'(i), 8'h01);
            tick();
            vecs++;
            if (bus.resp_result !== 8'(i + 1)) begin
                errs++;
                $display("FAIL wrap_result%0d got %h want %h", i, bus.resp_result, 8'(i + 1));
            end
            tick();
            vecs++;
            if (ops_count !== 4'((i + 1) % 16)) begin
                errs++;
                $display("FAIL wrap_count%0d got %0d want %0d", i, ops_count, (i + 1) % 16);
            end
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 4'd0;
        bus.req_a      = 8'h00;
        bus.req_b      = 8'h00;
        bus.resp_ready = 1'b0;
        test_reset();
        test_add();
        test_illegal();
        test_backpressure();
        test_reset_exec();
        test_back_to_back();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
